// File: rtl/noc_pkg.sv
// Shared NoC definitions: direction encodings, address fields, XY routing.
package noc_pkg;

  // One-hot port directions, also used as the switch request encoding
  localparam logic [4:0] DIR_L  = 5'b10000;
  localparam logic [4:0] DIR_R  = 5'b01000;
  localparam logic [4:0] DIR_U  = 5'b00100;
  localparam logic [4:0] DIR_D  = 5'b00010;
  localparam logic [4:0] DIR_PE = 5'b00001;

  // Address layout: X in the upper byte, Y in the lower byte
  localparam int ADDR_FIELD_W = 8;
  localparam int ADDR_X       = 8;
  localparam int ADDR_Y       = 0;

  // Presentation FSM states
  typedef enum logic {
    ST_IDLE,
    ST_LOCKED
  } lock_state_t;

  // Dimension-ordered routing: resolve X first, then Y, then eject
  function automatic logic [4:0] xy_route(input logic [15:0] cur,
                                          input logic [15:0] dest);
    logic [ADDR_FIELD_W-1:0] cx;
    logic [ADDR_FIELD_W-1:0] cy;
    logic [ADDR_FIELD_W-1:0] dx;
    logic [ADDR_FIELD_W-1:0] dy;
    cx = cur[ADDR_X +: ADDR_FIELD_W];
    cy = cur[ADDR_Y +: ADDR_FIELD_W];
    dx = dest[ADDR_X +: ADDR_FIELD_W];
    dy = dest[ADDR_Y +: ADDR_FIELD_W];
    if (dx > cx)      xy_route = DIR_R;
    else if (dx < cx) xy_route = DIR_L;
    else if (dy > cy) xy_route = DIR_U;
    else if (dy < cy) xy_route = DIR_D;
    else              xy_route = DIR_PE;
  endfunction

endpackage

// File: rtl/vc_fifo.sv
// Per-virtual-channel FIFO holding {route, flit}; any depth, wrap-around pointers.
module vc_fifo #(
  parameter int WIDTH = 69,
  parameter int DEPTH = 4,
  localparam int CW = $clog2(DEPTH + 1),
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic             clear,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic [CW-1:0]    count,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  // Pointers wrap at DEPTH-1 explicitly so non-power-of-two depths work
  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    if (p == PW'(DEPTH - 1)) next_ptr = '0;
    else                     next_ptr = p + 1'b1;
  endfunction

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr];

  // Pointer and occupancy bookkeeping; clear wins over push and pop
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= next_ptr(wr_ptr);
      if (do_pop)  rd_ptr <= next_ptr(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage array, written at the tail on every accepted push
  always_ff @(posedge clk) begin
    if (do_push && !clear) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/input_port_vc.sv
// Multi-VC router input port: buffers flits per VC, routes XY on write,
// and presents one locked head flit at a time to the switch allocator.
module input_port_vc import noc_pkg::*; #(
  parameter int          DATA_WIDTH      = 64,
  parameter logic [15:0] CURRENT_ADDRESS = 16'h0000,
  parameter logic [4:0]  DIRECTION       = 5'b00001,
  parameter int          VC_COUNT        = 2,
  parameter int          BUFFER_DEPTH    = 4,
  localparam int VCW = (VC_COUNT > 1) ? $clog2(VC_COUNT) : 1,
  localparam int CW  = $clog2(BUFFER_DEPTH + 1)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   si,
  input  logic [VCW-1:0]         vci,
  input  logic [DATA_WIDTH-1:0]  datai,
  output logic [VC_COUNT-1:0]    ri,
  input  logic                   sig_buffer_clear,
  input  logic [4:0]             gnt,
  output logic [4:0]             req,
  output logic [DATA_WIDTH-1:0]  datao,
  output logic [VCW-1:0]         vco,
  output logic [VC_COUNT*CW-1:0] occupancy,
  output logic                   route_err
);

  localparam int FW = DATA_WIDTH + 5;

  lock_state_t         state;
  logic                ready_en;
  logic [VCW-1:0]      rr_ptr;
  logic [4:0]          in_route;
  logic [FW-1:0]       fifo_dout  [VC_COUNT];
  logic [CW-1:0]       fifo_count [VC_COUNT];
  logic [VC_COUNT-1:0] fifo_full;
  logic [VC_COUNT-1:0] fifo_empty;
  logic [VC_COUNT-1:0] push_vec;
  logic [VC_COUNT-1:0] pop_vec;
  logic                grant_hit;
  logic                pick_valid;
  logic [VCW-1:0]      pick_vc;
  logic [FW-1:0]       head_word;

  assign in_route  = xy_route(CURRENT_ADDRESS, datai[15:0]);
  assign grant_hit = (state == ST_LOCKED) && (gnt == req) && !sig_buffer_clear;
  assign route_err = (|push_vec) && (in_route == DIRECTION) && (DIRECTION != DIR_PE);

  // Per-VC pop/ready/push; a full VC being popped this cycle still takes a flit
  always_comb begin
    pop_vec  = '0;
    ri       = '0;
    push_vec = '0;
    for (int v = 0; v < VC_COUNT; v++) begin
      pop_vec[v]  = grant_hit && (vco == VCW'(v));
      ri[v]       = ready_en && (!fifo_full[v] || pop_vec[v]);
      push_vec[v] = si && (vci == VCW'(v)) && ri[v] && !sig_buffer_clear;
    end
  end

  for (genvar g = 0; g < VC_COUNT; g++) begin : g_vc
    vc_fifo #(
      .WIDTH (FW),
      .DEPTH (BUFFER_DEPTH)
    ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push_vec[g]),
      .pop   (pop_vec[g]),
      .clear (sig_buffer_clear),
      .din   ({in_route, datai}),
      .dout  (fifo_dout[g]),
      .count (fifo_count[g]),
      .full  (fifo_full[g]),
      .empty (fifo_empty[g])
    );
    assign occupancy[g*CW +: CW] = fifo_count[g];
  end

  // Round-robin VC pick: first non-empty VC at or after the pointer
  always_comb begin
    pick_valid = 1'b0;
    pick_vc    = '0;
    for (int i = 0; i < VC_COUNT; i++) begin
      for (int v = 0; v < VC_COUNT; v++) begin
        if (!pick_valid && (v == (int'(rr_ptr) + i) % VC_COUNT) && !fifo_empty[v]) begin
          pick_valid = 1'b1;
          pick_vc    = VCW'(v);
        end
      end
    end
  end

  // Head word of the picked VC
  always_comb begin
    head_word = '0;
    for (int v = 0; v < VC_COUNT; v++) begin
      if (VCW'(v) == pick_vc) head_word = fifo_dout[v];
    end
  end

  // Upstream ready stays low through reset and rises on the first clock after it
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) ready_en <= 1'b0;
    else      ready_en <= 1'b1;
  end

  // Lock FSM: latch a head flit in IDLE, hold it until a matching grant pops it
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= ST_IDLE;
      rr_ptr <= '0;
      req    <= '0;
      datao  <= '0;
      vco    <= '0;
    end else if (sig_buffer_clear) begin
      state  <= ST_IDLE;
      rr_ptr <= '0;
      req    <= '0;
      datao  <= '0;
      vco    <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (pick_valid) begin
            state <= ST_LOCKED;
            req   <= head_word[FW-1 -: 5];
            datao <= head_word[DATA_WIDTH-1:0];
            vco   <= pick_vc;
          end
        end
        ST_LOCKED: begin
          if (grant_hit) begin
            state  <= ST_IDLE;
            req    <= '0;
            rr_ptr <= (vco == VCW'(VC_COUNT - 1)) ? '0 : vco + 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_input_port_vc.sv
// Scoreboard bench for input_port_vc: queue-based reference model, per-cycle
// checks of ready/occupancy/route_err/req, and a monitor matching presentations.
module tb_input_port_vc;

  localparam int          DW    = 64;
  localparam int          VCN   = 2;
  localparam int          DEPTH = 4;
  localparam int          CW    = 3;
  localparam logic [15:0] CUR   = 16'h0202;
  localparam logic [4:0]  DIR   = 5'b01000;

  logic              clk;
  logic              rst;
  logic              si;
  logic [0:0]        vci;
  logic [DW-1:0]     datai;
  logic [VCN-1:0]    ri;
  logic              sig_buffer_clear;
  logic [4:0]        gnt;
  logic [4:0]        req;
  logic [DW-1:0]     datao;
  logic [0:0]        vco;
  logic [VCN*CW-1:0] occupancy;
  logic              route_err;

  input_port_vc #(
    .DATA_WIDTH      (DW),
    .CURRENT_ADDRESS (CUR),
    .DIRECTION       (DIR),
    .VC_COUNT        (VCN),
    .BUFFER_DEPTH    (DEPTH)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .si               (si),
    .vci              (vci),
    .datai            (datai),
    .ri               (ri),
    .sig_buffer_clear (sig_buffer_clear),
    .gnt              (gnt),
    .req              (req),
    .datao            (datao),
    .vco              (vco),
    .occupancy        (occupancy),
    .route_err        (route_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] data;
    logic [4:0]  route;
    int          vc;
  } flit_t;

  flit_t          vcq [VCN][$];
  flit_t          exp_q [$];
  bit             m_locked;
  int             m_vc;
  logic [4:0]     m_req;
  logic [63:0]    m_data;
  int             m_rr;
  bit             m_ready_en;
  bit             m_pop_now;
  bit             m_wr;
  logic [VCN-1:0] exp_ri;

  int vectors;
  int miscompares;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    vectors++;
    if (act !== expv) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, act, expv, $time);
    end
  endtask

  // Reference XY routing from plain coordinate arithmetic
  function automatic logic [4:0] ref_route(input logic [15:0] dest);
    int dx, dy, cx, cy;
    dx = int'(dest) / 256;
    dy = int'(dest) % 256;
    cx = int'(CUR) / 256;
    cy = int'(CUR) % 256;
    if (dx > cx) return 5'b01000;
    if (dx < cx) return 5'b10000;
    if (dy > cy) return 5'b00100;
    if (dy < cy) return 5'b00010;
    return 5'b00001;
  endfunction

  function automatic logic [63:0] mk(input logic [15:0] addr);
    logic [31:0] hi;
    logic [15:0] mid;
    hi  = $urandom;
    mid = 16'($urandom);
    return {hi, mid, addr};
  endfunction

  // Compare the current cycle's outputs against the model (inputs already stable)
  task automatic checkOutput();
    logic [VCN*CW-1:0] exp_occ;
    m_pop_now = m_locked && (gnt == m_req) && !sig_buffer_clear;
    exp_occ   = '0;
    for (int v = 0; v < VCN; v++) begin
      exp_ri[v] = m_ready_en && ((vcq[v].size() < DEPTH) || (m_pop_now && m_vc == v));
      exp_occ[v*CW +: CW] = CW'(vcq[v].size());
    end
    m_wr = si && exp_ri[vci] && !sig_buffer_clear;
    chk("occupancy", occupancy, exp_occ);
    chk("ri", ri, exp_ri);
    chk("route_err", route_err, m_wr && (ref_route(datai[15:0]) == DIR) && (DIR != 5'b00001));
    chk("req", req, m_locked ? m_req : 5'b0);
    if (m_locked) begin
      chk("vco", vco, m_vc);
      chk("datao", datao, m_data);
    end
  endtask

  // Advance the reference model across one rising edge
  task automatic modelStep();
    flit_t tmp;
    bit    found;
    int    v;
    if (sig_buffer_clear) begin
      for (int k = 0; k < VCN; k++) vcq[k].delete();
      m_locked = 0;
      m_rr     = 0;
    end else begin
      if (m_locked) begin
        if (m_pop_now) begin
          tmp      = vcq[m_vc].pop_front();
          m_locked = 0;
          m_rr     = (m_vc + 1) % VCN;
        end
      end else begin
        found = 0;
        for (int i = 0; i < VCN; i++) begin
          v = (m_rr + i) % VCN;
          if (!found && vcq[v].size() > 0) begin
            found    = 1;
            m_locked = 1;
            m_vc     = v;
            m_req    = vcq[v][0].route;
            m_data   = vcq[v][0].data;
            exp_q.push_back(vcq[v][0]);
          end
        end
      end
      if (m_wr) begin
        tmp.data  = datai;
        tmp.route = ref_route(datai[15:0]);
        tmp.vc    = int'(vci);
        vcq[int'(vci)].push_back(tmp);
      end
    end
    m_ready_en = 1;
  endtask

  task automatic applyStimulus(input logic s, input int vc, input logic [63:0] d,
                               input logic [4:0] g, input logic c);
    si               = s;
    vci              = 1'(vc);
    datai            = d;
    gnt              = g;
    sig_buffer_clear = c;
    @(negedge clk);
    checkOutput();
    @(posedge clk);
    modelStep();
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(0, 0, 64'h0, 5'b0, 0);
  endtask

  task automatic grantCycle();
    applyStimulus(0, 0, 64'h0, m_locked ? m_req : 5'b0, 0);
  endtask

  task automatic sendAndDrain(input int vc, input logic [15:0] addr);
    applyStimulus(1, vc, mk(addr), 5'b0, 0);
    idle(2);
    grantCycle();
    idle(1);
  endtask

  // Asynchronous reset mid-cycle, then release between edges
  task automatic doReset();
    #2;
    rst              = 1'b0;
    si               = 1'b0;
    gnt              = 5'b0;
    sig_buffer_clear = 1'b0;
    #1;
    chk("rst_req", req, 5'b0);
    chk("rst_datao", datao, 64'h0);
    chk("rst_vco", vco, 1'b0);
    chk("rst_occupancy", occupancy, '0);
    chk("rst_ri", ri, '0);
    chk("rst_route_err", route_err, 1'b0);
    for (int k = 0; k < VCN; k++) vcq[k].delete();
    m_locked   = 0;
    m_rr       = 0;
    m_ready_en = 0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("ri_after_release", ri, '0);
    @(posedge clk);
    m_ready_en = 1;
    #1;
  endtask

  // Monitor: every new presentation must match the next expected flit
  logic [4:0] prev_req = 5'b0;
  always @(negedge clk) begin
    flit_t e;
    if (rst === 1'b1 && req != 5'b0 && prev_req == 5'b0) begin
      if (exp_q.size() == 0) begin
        chk("sb_unexpected", req, 5'b0);
      end else begin
        e = exp_q.pop_front();
        chk("sb_vco", vco, e.vc);
        chk("sb_data", datao, e.data);
        chk("sb_route", req, e.route);
      end
    end
    prev_req = (rst === 1'b1) ? req : 5'b0;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [4:0] g;
    int         r;
    vectors          = 0;
    miscompares      = 0;
    rst              = 1'b0;
    si               = 1'b0;
    vci              = 1'b0;
    datai            = '0;
    gnt              = 5'b0;
    sig_buffer_clear = 1'b0;
    m_locked         = 0;
    m_vc             = 0;
    m_req            = 5'b0;
    m_data           = '0;
    m_rr             = 0;
    m_ready_en       = 0;
    @(posedge clk);
    #1;
    doReset();

    $display("[TB] routing and U-turn");
    applyStimulus(1, 0, mk(16'h0302), 5'b0, 0);
    idle(2);
    applyStimulus(0, 0, 64'h0, 5'b10000, 0);
    applyStimulus(0, 0, 64'h0, 5'b10000, 0);
    grantCycle();
    idle(1);
    sendAndDrain(0, 16'h0202);
    sendAndDrain(0, 16'h0201);
    sendAndDrain(1, 16'h0102);
    sendAndDrain(1, 16'h0203);

    $display("[TB] fill VC1, overflow drop, pop-and-push on full");
    for (int i = 0; i < 4; i++) applyStimulus(1, 1, mk(16'h0203), 5'b0, 0);
    applyStimulus(1, 1, mk(16'h0101), 5'b0, 0);
    idle(1);
    applyStimulus(1, 1, mk(16'h0302), m_req, 0);
    for (int i = 0; i < 12; i++) grantCycle();

    $display("[TB] round-robin alternation");
    for (int i = 0; i < 4; i++) applyStimulus(1, i % 2, mk(16'h0200 + 16'(i)), 5'b0, 0);
    for (int i = 0; i < 10; i++) grantCycle();

    $display("[TB] buffer clear");
    for (int i = 0; i < 3; i++) applyStimulus(1, i % 2, mk(16'h0303), 5'b0, 0);
    idle(1);
    applyStimulus(1, 0, mk(16'h0101), m_locked ? m_req : 5'b0, 1);
    idle(2);
    sendAndDrain(1, 16'h0302);

    $display("[TB] randomized traffic");
    for (int i = 0; i < 400; i++) begin
      r = $urandom_range(0, 99);
      if (m_locked && r < 50)  g = m_req;
      else if (r < 70)         g = 5'(1) << $urandom_range(0, 4);
      else                     g = 5'b0;
      applyStimulus(($urandom_range(0, 99) < 50) ? 1'b1 : 1'b0,
                    $urandom_range(0, 1),
                    mk({8'($urandom_range(1, 3)), 8'($urandom_range(1, 3))}),
                    g,
                    ($urandom_range(0, 99) < 2) ? 1'b1 : 1'b0);
    end

    $display("[TB] reset while locked");
    applyStimulus(1, 0, mk(16'h0102), 5'b0, 0);
    idle(2);
    doReset();
    sendAndDrain(0, 16'h0204);

    for (int i = 0; i < 40; i++) begin
      if (!m_locked && vcq[0].size() == 0 && vcq[1].size() == 0) break;
      grantCycle();
    end
    idle(2);
    chk("sb_drain", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
